// File: rtl/cpu_bus_mem.sv
// cpu_bus_mem: wait-state-capable memory slave for the CPU data bus.
// An access is sampled in IDLE, optionally held for WAIT_STATES cycles in
// WAIT, and resolved in RESP. The response (READY, ERR, read data) is
// registered on the edge that leaves RESP. READY therefore pulses for one
// cycle, (1 + WAIT_STATES) edges after the edge that sampled CS.
// Optional build macro: CPU_BUS_MEM_TRISTATE_EN. When it is defined,
// Data_BUS_READ is high-Z except while a read response is being presented.
module cpu_bus_mem #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int ALIGN_CHECK = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] Data_BUS_WRITE,
    input  logic              CS,
    input  logic              WR,
    output logic [DATA_W-1:0] Data_BUS_READ,
    output logic              READY,
    output logic              ERR
);

    localparam int LSB   = $clog2(DATA_W / 8);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Any address bit above the word-index field set means out of range.
    function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] a);
        logic r;
        r = 1'b0;
        for (int i = LSB + IDX_W; i < ADDR_W; i++) begin
            r = r | a[i];
        end
        return r;
    endfunction

    // Non-zero byte-lane bits mean misaligned, when alignment is enforced.
    function automatic logic addr_misaligned(input logic [ADDR_W-1:0] a);
        logic r;
        r = 1'b0;
        for (int i = 0; i < LSB; i++) begin
            r = r | a[i];
        end
        return r & (ALIGN_CHECK != 0);
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [IDX_W-1:0]  lidx_q,   lidx_d;
    logic [DATA_W-1:0] lwdata_q, lwdata_d;
    logic              lwr_q,    lwr_d;
    logic              lerr_q,   lerr_d;
    logic              ready_q,  ready_d;
    logic              err_q,    err_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
`ifdef CPU_BUS_MEM_TRISTATE_EN
    logic              drive_q,  drive_d;
`endif

    // Next-state, request latching and response computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lidx_d   = lidx_q;
        lwdata_d = lwdata_q;
        lwr_d    = lwr_q;
        lerr_d   = lerr_q;
        ready_d  = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
`ifdef CPU_BUS_MEM_TRISTATE_EN
        drive_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (CS) begin
                    lidx_d   = ADDR[LSB +: IDX_W];
                    lwdata_d = Data_BUS_WRITE;
                    lwr_d    = WR;
                    lerr_d   = addr_out_of_range(ADDR) | addr_misaligned(ADDR);
                    cnt_d    = CNT_W'(WAIT_STATES);
                    state_d  = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!CS) begin
                    // Master withdrew the request: abandon without effect.
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                ready_d = 1'b1;
                err_d   = lerr_q;
                if (lerr_q) begin
                    rdata_d = {DATA_W{1'b0}};
                end else if (!lwr_q) begin
                    rdata_d = mem_q[lidx_q];
                end else begin
                    rdata_d = rdata_q;
                end
`ifdef CPU_BUS_MEM_TRISTATE_EN
                drive_d = ~lwr_q;
`endif
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Control state, latched request and registered response outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            lidx_q   <= {IDX_W{1'b0}};
            lwdata_q <= {DATA_W{1'b0}};
            lwr_q    <= 1'b0;
            lerr_q   <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= {DATA_W{1'b0}};
`ifdef CPU_BUS_MEM_TRISTATE_EN
            drive_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lidx_q   <= lidx_d;
            lwdata_q <= lwdata_d;
            lwr_q    <= lwr_d;
            lerr_q   <= lerr_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
`ifdef CPU_BUS_MEM_TRISTATE_EN
            drive_q  <= drive_d;
`endif
        end
    end

    // Storage array: written only when a good write resolves; never reset.
    always_ff @(posedge CLK) begin
        if (state_q == S_RESP && lwr_q && !lerr_q && !RST) begin
            mem_q[lidx_q] <= lwdata_q;
        end
    end

    assign READY = ready_q;
    assign ERR   = err_q;
`ifdef CPU_BUS_MEM_TRISTATE_EN
    assign Data_BUS_READ = drive_q ? rdata_q : {DATA_W{1'bz}};
`else
    assign Data_BUS_READ = rdata_q;
`endif

endmodule

// File: tb/tb_cpu_bus_mem.sv
// Directed bench for cpu_bus_mem: a zero-wait-state aligned instance and a
// three-wait-state instance with alignment checking disabled.
module tb_cpu_bus_mem;

    localparam int WS0 = 0;
    localparam int WS1 = 3;

    logic        clk;
    logic        rst   [2];
    logic        cs    [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    wire  [31:0] rdata0, rdata1;
    wire         ready0, ready1, err0, err1;

    int tests = 0;
    int fails = 0;

    cpu_bus_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_STATES(WS0), .ALIGN_CHECK(1)) u_ws0 (
        .CLK(clk), .RST(rst[0]), .ADDR(addr[0]), .Data_BUS_WRITE(wdata[0]), .CS(cs[0]), .WR(wr[0]),
        .Data_BUS_READ(rdata0), .READY(ready0), .ERR(err0)
    );

    cpu_bus_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_STATES(WS1), .ALIGN_CHECK(0)) u_ws3 (
        .CLK(clk), .RST(rst[1]), .ADDR(addr[1]), .Data_BUS_WRITE(wdata[1]), .CS(cs[1]), .WR(wr[1]),
        .Data_BUS_READ(rdata1), .READY(ready1), .ERR(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rdy(input int i);
        return (i == 0) ? ready0 : ready1;
    endfunction
    function automatic logic erf(input int i);
        return (i == 0) ? err0 : err1;
    endfunction
    function automatic logic [31:0] rdv(input int i);
        return (i == 0) ? rdata0 : rdata1;
    endfunction
    function automatic int wsof(input int i);
        return (i == 0) ? WS0 : WS1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start at a negedge; returns at the negedge where READY is seen (CS dropped).
    task automatic access(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic e);
        cs[i] = 1'b1; wr[i] = w; addr[i] = a; wdata[i] = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rdy(i) && lat < 40);
        rd = rdv(i);
        e  = erf(i);
        cs[i] = 1'b0;
    endtask

    // Count READY pulses over n cycles.
    task automatic count_ready(input int i, input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (rdy(i)) cnt++;
        end
    endtask

    // Four accesses with CS held high throughout.
    task automatic b2b(input int i);
        logic        ow [4];
        logic [31:0] oa [4];
        logic [31:0] od [4];
        int n, idx, per;
        ow[0] = 1'b1; oa[0] = 32'h4; od[0] = 32'h1;
        ow[1] = 1'b1; oa[1] = 32'h8; od[1] = 32'h2;
        ow[2] = 1'b0; oa[2] = 32'h4; od[2] = 32'h0;
        ow[3] = 1'b0; oa[3] = 32'h8; od[3] = 32'h0;
        per = wsof(i) + 2;
        n = 0; idx = 0;
        cs[i] = 1'b1; wr[i] = ow[0]; addr[i] = oa[0]; wdata[i] = od[0];
        while (idx < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (rdy(i)) begin
                chk("b2b_time", n, per * (idx + 1));
                chk("b2b_err", {31'd0, erf(i)}, 32'd0);
                if (!ow[idx]) chk("b2b_data", rdv(i), od[idx - 2]);
                idx++;
                if (idx < 4) begin
                    wr[i] = ow[idx]; addr[i] = oa[idx]; wdata[i] = od[idx];
                end else begin
                    cs[i] = 1'b0;
                end
            end
        end
        chk("b2b_count", idx, 32'd4);
        cs[i] = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int          lat, cnt;
        logic [31:0] rd;
        logic        e;

        // Expected data for writes is the held value from the last read/error.
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0000, 32'hCAFE_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_1000, 32'h1111_1111, 32'h0000_0000, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hCAFE_0000, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[6] = '{1'b1, 32'h0000_0FFC, 32'h5A5A_5A5A, 32'h0000_0000, 1'b0};
        vecs[7] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 32'h5A5A_5A5A, 1'b0};
        vecs[8] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[9] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; cs[i] = 1'b1; wr[i] = 1'b1;
            addr[i] = 32'h0; wdata[i] = 32'hBAD0_BAD0;
        end
        #100;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", {31'd0, rdy(i)}, 32'd0);
            chk("rst_err", {31'd0, erf(i)}, 32'd0);
`ifdef CPU_BUS_MEM_TRISTATE_EN
            chk("rst_data", rdv(i), 32'hzzzz_zzzz);
`else
            chk("rst_data", rdv(i), 32'h0);
`endif
            cs[i] = 1'b0;
            rst[i] = 1'b0;
        end
        @(negedge clk);

        // Table-driven accesses on the zero-wait-state instance.
        for (int v = 0; v < 10; v++) begin
            access(0, vecs[v].wr, vecs[v].addr, vecs[v].wdata, lat, rd, e);
            chk($sformatf("v%0d_latency", v), lat, WS0 + 2);
            chk($sformatf("v%0d_err", v), {31'd0, e}, {31'd0, vecs[v].exp_err});
`ifdef CPU_BUS_MEM_TRISTATE_EN
            if (!vecs[v].wr) chk($sformatf("v%0d_data", v), rd, vecs[v].exp_data);
`else
            chk($sformatf("v%0d_data", v), rd, vecs[v].exp_data);
`endif
            @(negedge clk);
            chk($sformatf("v%0d_pulse", v), {31'd0, rdy(0)}, 32'd0);
        end

        b2b(0);

        // Wait-state instance: latency, abort, alignment disabled, reset abort.
        access(1, 1'b1, 32'h20, 32'h0BAD_F00D, lat, rd, e);
        chk("ws3_wr_latency", lat, WS1 + 2);
        @(negedge clk);
        access(1, 1'b0, 32'h20, 32'h0, lat, rd, e);
        chk("ws3_rd_latency", lat, WS1 + 2);
        chk("ws3_rd_data", rd, 32'h0BAD_F00D);
        @(negedge clk);
        chk("ws3_pulse", {31'd0, rdy(1)}, 32'd0);

        cs[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        cs[1] = 1'b0;
        count_ready(1, 8, cnt);
        chk("abort_no_ready", cnt, 32'd0);
        access(1, 1'b0, 32'h20, 32'h0, lat, rd, e);
        chk("abort_latency", lat, WS1 + 2);
        chk("abort_mem_kept", rd, 32'h0BAD_F00D);
        @(negedge clk);

        access(1, 1'b1, 32'h0, 32'h0000_0077, lat, rd, e);
        @(negedge clk);
        access(1, 1'b0, 32'h2, 32'h0, lat, rd, e);
        chk("noalign_err", {31'd0, e}, 32'd0);
        chk("noalign_data", rd, 32'h0000_0077);
        @(negedge clk);

        access(1, 1'b1, 32'h30, 32'h600D_CAFE, lat, rd, e);
        @(negedge clk);
        cs[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h30; wdata[1] = 32'hAAAA_5555;
        @(negedge clk);
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {31'd0, rdy(1)}, 32'd0);
        chk("midrst_err", {31'd0, erf(1)}, 32'd0);
`ifndef CPU_BUS_MEM_TRISTATE_EN
        chk("midrst_data", rdv(1), 32'h0);
`endif
        cs[1] = 1'b0;
        rst[1] = 1'b0;
        count_ready(1, 8, cnt);
        chk("midrst_no_ready", cnt, 32'd0);
        access(1, 1'b0, 32'h30, 32'h0, lat, rd, e);
        chk("midrst_mem_kept", rd, 32'h600D_CAFE);
        @(negedge clk);

        b2b(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
